// File: rtl/fetch_prefetch_if.sv
// rtl/fetch_prefetch_if.sv - instruction-memory request/response bundle for fetch_prefetch
// Ports:
//   imem_req, imem_addr                  fetch -> memory (request)
//   imem_ready                           memory -> fetch (request accepted when req && ready)
//   imem_rvalid, imem_rdata              memory -> fetch (in-order responses)
interface fetch_prefetch_if #(
   parameter int XLEN = 32
);
   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ready;
   logic            imem_rvalid;
   logic [31:0]     imem_rdata;

   modport master (
      output imem_req,
      output imem_addr,
      input  imem_ready,
      input  imem_rvalid,
      input  imem_rdata
   );

   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_ready,
      output imem_rvalid,
      output imem_rdata
   );
endinterface

// File: rtl/fetch_prefetch.sv
// rtl/fetch_prefetch.sv - instruction fetch stage with in-order prefetch queue and redirect flush
// Ports:
//   clk, rst (async, active-low)
//   PCSrc, PCTarget                      redirect from execute
//   StallD                               hold decode outputs
//   imem (master)                        decoupled instruction-memory request/response
//   InstrD, PCD, inc_PCD, ValidD         F/D register outputs to decode
module fetch_prefetch #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PCSrc,
   input  logic [XLEN-1:0]  PCTarget,
   input  logic             StallD,
   fetch_prefetch_if.master imem,
   output logic [31:0]      InstrD,
   output logic [XLEN-1:0]  PCD,
   output logic [XLEN-1:0]  inc_PCD,
   output logic             ValidD
);
   localparam int          PW      = $clog2(DEPTH);
   localparam int          CW      = $clog2(DEPTH + 1);
   localparam logic [31:0] NOP     = 32'h0000_0013;
   localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

   logic [XLEN-1:0]  pcf;
   logic [XLEN-1:0]  q_pc    [DEPTH];
   logic [31:0]      q_instr [DEPTH];
   logic [DEPTH-1:0] q_filled;
   logic [PW-1:0]    head;
   logic [PW-1:0]    tail;
   logic [PW-1:0]    fill;
   logic [CW-1:0]    count;
   // allocated-but-unfilled entries; on redirect these become stale responses to drop
   logic [CW-1:0]    pending;
   logic [CW-1:0]    drop_cnt;

   logic accept;
   logic head_ready;
   logic pop;
   logic resp_fill;

   // Gated by rst so no request escapes while reset is held, without waiting for a clock.
   assign imem.imem_req  = rst && !PCSrc && (({1'b0, count} + {1'b0, drop_cnt}) < DEPTH_C);
   assign imem.imem_addr = pcf;

   assign accept     = imem.imem_req && imem.imem_ready;
   assign head_ready = (count != '0) && q_filled[head];
   assign pop        = !PCSrc && !StallD && head_ready;
   assign resp_fill  = imem.imem_rvalid && (drop_cnt == '0);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pcf      <= RESET_PC;
         head     <= '0;
         tail     <= '0;
         fill     <= '0;
         count    <= '0;
         pending  <= '0;
         drop_cnt <= '0;
         q_filled <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_pc[i]    <= '0;
            q_instr[i] <= '0;
         end
         InstrD   <= NOP;
         PCD      <= '0;
         inc_PCD  <= '0;
         ValidD   <= 1'b0;
      end else if (PCSrc) begin
         pcf      <= PCTarget;
         head     <= '0;
         tail     <= '0;
         fill     <= '0;
         count    <= '0;
         pending  <= '0;
         // A response landing this cycle is stale either way: it consumes one drop
         // or fills an entry that is being thrown away.
         drop_cnt <= drop_cnt + pending - CW'(imem.imem_rvalid);
         InstrD   <= NOP;
         ValidD   <= 1'b0;
      end else begin
         if (accept) begin
            q_pc[tail]     <= pcf;
            q_filled[tail] <= 1'b0;
            tail           <= tail + PW'(1);
            pcf            <= pcf + XLEN'(4);
         end
         if (imem.imem_rvalid) begin
            if (drop_cnt != '0) begin
               drop_cnt <= drop_cnt - CW'(1);
            end else begin
               q_instr[fill]  <= imem.imem_rdata;
               q_filled[fill] <= 1'b1;
               fill           <= fill + PW'(1);
            end
         end
         if (!StallD) begin
            if (head_ready) begin
               InstrD  <= q_instr[head];
               PCD     <= q_pc[head];
               inc_PCD <= q_pc[head] + XLEN'(4);
               ValidD  <= 1'b1;
               head    <= head + PW'(1);
            end else begin
               InstrD  <= NOP;
               ValidD  <= 1'b0;
            end
         end
         count   <= count + CW'(accept) - CW'(pop);
         pending <= pending + CW'(accept) - CW'(resp_fill);
      end
   end
endmodule

// File: tb/tb_fetch_prefetch.sv
// tb/tb_fetch_prefetch.sv - scoreboard bench for fetch_prefetch
module tb_fetch_prefetch;
   localparam int          XLEN  = 32;
   localparam int          DEPTH = 4;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk      = 1'b0;
   logic        rst      = 1'b0;
   logic        PCSrc    = 1'b0;
   logic        StallD   = 1'b0;
   logic [31:0] PCTarget = '0;
   logic [31:0] InstrD;
   logic [31:0] PCD;
   logic [31:0] inc_PCD;
   logic        ValidD;

   fetch_prefetch_if #(.XLEN(XLEN)) imem ();

   fetch_prefetch #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
      .clk      (clk),
      .rst      (rst),
      .PCSrc    (PCSrc),
      .PCTarget (PCTarget),
      .StallD   (StallD),
      .imem     (imem),
      .InstrD   (InstrD),
      .PCD      (PCD),
      .inc_PCD  (inc_PCD),
      .ValidD   (ValidD)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 1;
   int          max_out = 0;
   int          first_acc = -1;
   int          first_valid = -1;
   int          bubbles = 0;
   logic [31:0] exp_q [$];
   logic [31:0] mq_addr [$];
   int          mq_due [$];
   logic        ld_prev = 1'b0;
   logic        redir_prev = 1'b0;
   logic [31:0] last_pcd = '0;
   logic [31:0] last_inc = '0;
   logic [31:0] last_instr = NOP;
   logic        last_valid = 1'b0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(posedge clk) cyc = cyc + 1;

   // Memory model: in-order, fixed latency 'lat', data = ~address. Runs after stimulus.
   initial begin
      imem.imem_rvalid = 1'b0;
      imem.imem_rdata  = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst) begin
            mq_addr.delete();
            mq_due.delete();
            imem.imem_rvalid = 1'b0;
            first_acc = -1;
         end else begin
            if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
               imem.imem_rvalid = 1'b1;
               imem.imem_rdata  = ~mq_addr[0];
               void'(mq_addr.pop_front());
               void'(mq_due.pop_front());
            end else begin
               imem.imem_rvalid = 1'b0;
            end
            if (imem.imem_req && imem.imem_ready) begin
               mq_addr.push_back(imem.imem_addr);
               mq_due.push_back(cyc + lat);
               if (first_acc < 0) first_acc = cyc;
               if (mq_addr.size() > max_out) max_out = mq_addr.size();
            end
         end
         #1;
         ld_prev    = !StallD && !PCSrc;
         redir_prev = PCSrc;
      end
   end

   // Monitor: classifies each F/D update and checks it against the scoreboard.
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst) begin
         last_pcd    = '0;
         last_inc    = '0;
         last_instr  = NOP;
         last_valid  = 1'b0;
         first_valid = -1;
      end else begin
         if (redir_prev) begin
            chk("redirect_bubble", {31'd0, ValidD, InstrD, PCD}, {32'd0, NOP, last_pcd});
         end else if (!ld_prev) begin
            chk("stall_hold", {31'd0, ValidD, InstrD, PCD}, {31'd0, last_valid, last_instr, last_pcd});
         end else if (ValidD) begin
            if (first_valid < 0) first_valid = cyc;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: got PCD=%h InstrD=%h expected no instruction", PCD, InstrD);
            end else begin
               e = exp_q.pop_front();
               chk("decode", {InstrD, PCD, inc_PCD}, {~e, e, e + 32'd4});
            end
         end else begin
            bubbles++;
            chk("bubble", {InstrD, PCD, inc_PCD}, {NOP, last_pcd, last_inc});
         end
         last_pcd   = PCD;
         last_inc   = inc_PCD;
         last_instr = InstrD;
         last_valid = ValidD;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         step();
         n++;
      end
      chk({name, "_drained"}, 96'(exp_q.size()), 96'd0);
      exp_q.delete();
   endtask

   task automatic redirect(input logic [31:0] tgt, input int n);
      PCSrc    = 1'b1;
      PCTarget = tgt;
      for (int i = 0; i < n; i++) exp_q.push_back(tgt + 32'(4 * i));
      step();
      PCSrc    = 1'b0;
      PCTarget = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] gap_addr;
      int          b0;
      imem.imem_ready = 1'b1;
      step();
      step();
      chk("reset_ValidD", {95'd0, ValidD}, 96'd0);
      chk("reset_InstrD", {64'd0, InstrD}, {64'd0, NOP});
      chk("reset_PCD", {64'd0, PCD}, 96'd0);
      chk("reset_inc_PCD", {64'd0, inc_PCD}, 96'd0);
      chk("reset_imem_req", {95'd0, imem.imem_req}, 96'd0);

      for (int i = 0; i < 24; i++) exp_q.push_back(32'(4 * i));
      rst = 1'b1;
      repeat (6) step();

      imem.imem_ready = 1'b0;
      gap_addr = imem.imem_addr;
      b0 = bubbles;
      repeat (5) begin
         step();
         chk("gap_addr_hold", {64'd0, imem.imem_addr}, {64'd0, gap_addr});
      end
      chk("gap_bubbles_seen", {95'd0, bubbles > b0}, 96'd1);
      imem.imem_ready = 1'b1;
      repeat (4) step();

      StallD = 1'b1;
      step();
      step();
      step();
      chk("stall_issue_blocked", {95'd0, imem.imem_req}, 96'd0);
      step();
      StallD = 1'b0;
      drain("stream0");
      chk("first_fetch_latency", 96'(first_valid - first_acc), 96'd3);

      lat = 3;
      redirect(32'h0000_0080, 6);
      drain("lat3_stream");
      redirect(32'h0000_0100, 4);
      drain("redirect_0x100");
      redirect(32'h0000_0200, 0);
      step();
      redirect(32'h0000_0300, 6);
      drain("double_redirect");

      lat = 1;
      redirect(32'hFFFF_FFF8, 4);
      drain("wrap");

      redirect(32'h0000_0040, 20);
      repeat (8) step();
      rst = 1'b0;
      #1;
      chk("midreset_ValidD", {95'd0, ValidD}, 96'd0);
      chk("midreset_InstrD", {64'd0, InstrD}, {64'd0, NOP});
      chk("midreset_PCD", {64'd0, PCD}, 96'd0);
      chk("midreset_inc_PCD", {64'd0, inc_PCD}, 96'd0);
      chk("midreset_imem_req", {95'd0, imem.imem_req}, 96'd0);
      exp_q.delete();
      step();
      step();
      for (int i = 0; i < 4; i++) exp_q.push_back(32'(4 * i));
      rst = 1'b1;
      drain("post_reset");
      chk("post_reset_latency", 96'(first_valid - first_acc), 96'd3);
      chk("max_outstanding_le_depth", {95'd0, max_out <= DEPTH}, 96'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Parametrised instruction-fetch stage with a decoupled instruction-memory request/response interface and an in-order prefetch queue of DEPTH entries. It replaces the single-cycle fetch path feeding the F/D pipeline register. It adds:
- variable-latency memory support with up to DEPTH requests in flight
- decode-side stall
- branch/jump redirect that flushes queued and in-flight fetches

Its outputs drive the decode stage directly.

## Interface
Parameters:
- XLEN, 32: PC/address width.
- DEPTH, 4: prefetch queue entries; power of two, ≥2. Full throughput with 1-cycle memory needs ≥3.
- RESET_PC, 0: first fetch address after reset.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset; all state cleared while low.
- PCSrc  in  1  redirect request from execute.
- PCTarget  in  XLEN  redirect target; valid when PCSrc=1.
- StallD  in  1  hold decode outputs.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address (= PCF).
- imem_ready  in  1  memory accepts request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid; responses in request order, ≥1 cycle after acceptance.
- imem_rdata  in  32  response instruction.
- InstrD  out  32  decode instruction.
- PCD  out  XLEN  PC of InstrD.
- inc_PCD  out  XLEN  PCD+4.
- ValidD  out  1  InstrD is a real instruction, not a bubble.

## Operation
- State:
  - PCF register.
  - Circular queue of DEPTH entries {pc, instr, filled}, with head, tail and fill pointers.
  - count: allocated entries.
  - drop_cnt: stale responses still to discard, width clog2(DEPTH+1).
  - F/D output register.
- Issue: imem_req = !PCSrc && (count + drop_cnt < DEPTH). On acceptance:
  - allocate the tail entry with pc=PCF, filled=0;
  - PCF ← PCF+4, modulo 2^XLEN, wraps silently.
- Response:
  - If drop_cnt>0: discard imem_rdata and decrement drop_cnt.
  - Otherwise: write imem_rdata into the entry at the fill pointer, set filled, advance the fill pointer.
- Decode load, when !StallD and !PCSrc:
  - If head is filled: InstrD/PCD ← head, inc_PCD ← head.pc+4, ValidD ← 1, pop head.
  - Otherwise: bubble, i.e. InstrD ← 0x00000013 (NOP), ValidD ← 0; PCD/inc_PCD hold.
- StallD=1 and PCSrc=0: F/D register and queue head hold. Issue and fill continue while space allows.
- Redirect (PCSrc=1), overriding StallD:
  - PCF ← PCTarget; no issue this cycle.
  - Queue emptied: count ← 0, all pointers reset.
  - drop_cnt ← drop_cnt + (allocated-but-unfilled entries) − (imem_rvalid this cycle).
  - F/D register loads a bubble.
- Simultaneous events:
  - A response arriving in a redirect cycle is stale and is accounted for by the drop_cnt update above.
  - Pop and allocate in the same cycle leave count unchanged.
- Invariant: count + drop_cnt ≤ DEPTH, which is also the outstanding-request bound.

## Timing
- Reset values:
  - PCF=RESET_PC, queue empty, drop_cnt=0.
  - InstrD=0x00000013, PCD=0, inc_PCD=0, ValidD=0.
  - imem_req=0 while rst low.
- imem_req is combinational from state and PCSrc; imem_addr = PCF.
- Latency with 1-cycle memory:
  - request accepted in cycle n, rvalid in n+1;
  - head is filled in n+2 and loaded at the end of n+2;
  - ValidD=1 in n+3.
- Sustained throughput is 1 instruction/cycle with 1-cycle memory and DEPTH≥3.
- After a redirect in cycle r: first request to PCTarget in r+1. ValidD stays 0 until that response is filled and loaded; stale responses never reach InstrD.
- rst asserted mid-operation: immediate return to reset values. Responses to pre-reset requests are not expected by the block; the memory must be reset alongside.

## Test plan
- Reset release, RESET_PC=0, 1-cycle memory returning addr-tagged words -> ValidD rises 3 cycles after the first acceptance, then PCD = 0, 4, 8, … on consecutive cycles with inc_PCD = PCD+4.
- imem_ready=0 for 5 cycles, then 1 -> ValidD=0 bubbles (InstrD=0x13) during the gap, no PC skipped or duplicated, imem_addr holds its value.
- StallD=1 for 4 cycles mid-stream -> InstrD/PCD held. Issue stops once count=DEPTH (4 requests beyond the held instruction). After release, the sequence resumes with no loss.
- 3-cycle memory with 3 requests in flight, PCSrc=1, PCTarget=0x100 -> drop_cnt=3, 3 responses discarded, next ValidD instruction has PCD=0x100.
- Two redirects 1 cycle apart (targets 0x200 then 0x300) with responses still pending -> only 0x300, 0x304, … reach decode; count+drop_cnt never exceeds DEPTH.
- XLEN=32, PCF=0xFFFFFFFC -> next fetch address wraps to 0x00000000; rst pulsed low mid-stream -> all outputs return to reset values asynchronously.
